// File: rtl/ledpause_blink_ctrl.sv
// LED pause sequencer: CSR-programmed steady/blink level pushed to the PIO over Avalon-MM.
// CSR write reaches the PIO 2 edges later; m_waitrequest stretches the write while blink timing keeps running.
module ledpause_blink_ctrl #(
  parameter int unsigned DEFAULT_HALF_PERIOD = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  localparam logic [1:0]  ADDR_CTRL   = 2'd0;
  localparam logic [1:0]  ADDR_PERIOD = 2'd1;
  localparam logic [1:0]  ADDR_STATUS = 2'd2;
  localparam logic [31:0] PERIOD_RST  = 32'(DEFAULT_HALF_PERIOD);
  localparam logic [31:0] PERIOD_MIN  = 32'd2;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_t;

  state_t      state;
  logic        ctrl_en;
  logic        ctrl_mode;
  logic [31:0] period;
  logic [31:0] cnt;
  logic        phase;
  logic        led;
  logic        wr_level;

  logic        csr_wr;
  logic        ctrl_wr;
  logic        period_wr;
  logic        blinking;
  logic        target;

  assign csr_wr    = chipselect & ~write_n;
  assign ctrl_wr   = csr_wr && (address == ADDR_CTRL);
  assign period_wr = csr_wr && (address == ADDR_PERIOD);
  assign blinking  = ctrl_en & ctrl_mode;
  assign target    = ctrl_en & (~ctrl_mode | phase);

  assign m_address   = 2'd0;
  assign m_writedata = {31'd0, wr_level};

  // Any CTRL/PERIOD write restarts the blink on the lit half, and wins over a wrap in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 1'b0;
      period    <= PERIOD_RST;
      cnt       <= 32'd0;
      phase     <= 1'b1;
    end else begin
      if (ctrl_wr) begin
        ctrl_en   <= writedata[0];
        ctrl_mode <= writedata[1];
      end
      if (period_wr) begin
        period <= (writedata < PERIOD_MIN) ? PERIOD_MIN : writedata;
      end
      if (ctrl_wr || period_wr || !blinking) begin
        cnt   <= 32'd0;
        phase <= 1'b1;
      end else if (cnt == period - 32'd1) begin
        cnt   <= 32'd0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // One write in flight; the level is frozen at launch so target changes mid-stall wait for IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      led          <= 1'b0;
      wr_level     <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (target != led) begin
            state        <= ST_WRITE;
            wr_level     <= target;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (!m_waitrequest) begin
            state        <= ST_IDLE;
            led          <= wr_level;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:   readdata = {30'd0, ctrl_mode, ctrl_en};
      ADDR_PERIOD: readdata = period;
      ADDR_STATUS: readdata = {30'd0, (state == ST_WRITE), led};
      default:     readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_ledpause_blink_ctrl.sv
// Bench for ledpause_blink_ctrl: model predicts each PIO write (level and completion edge), monitor checks them.
module tb_ledpause_blink_ctrl;

  localparam int unsigned DEF = 25000000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  always #5 clk = ~clk;

  ledpause_blink_ctrl #(.DEFAULT_HALF_PERIOD(DEF)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_waitrequest(m_waitrequest)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // PIO slave: stalls each write for stall_n cycles.
  int stall_n = 0;
  int stall_cnt = 0;
  assign m_waitrequest = m_chipselect && (stall_cnt < stall_n);
  always @(posedge clk) stall_cnt <= (m_chipselect && m_waitrequest) ? stall_cnt + 1 : 0;

  // Reference model state (values after the most recent edge).
  bit     md_en = 0, md_mode = 0, md_led = 0, md_busy = 0, md_wr = 0;
  longint md_period = DEF;
  longint cyc = 0, bstart = 0, done_at = 0;
  bit     exp_lvl[$];
  longint exp_cyc[$];

  function automatic bit tgt(longint c);
    if (!md_en) return 1'b0;
    if (!md_mode) return 1'b1;
    return (((c - bstart) / md_period) % 2) == 0;
  endfunction

  function automatic logic [31:0] exp_rd(logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, md_mode, md_en};
      2'd1:    return 32'(md_period);
      2'd2:    return {30'd0, md_busy, md_led};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    bit t;
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      if (md_busy) begin
        void'(exp_lvl.pop_back());
        void'(exp_cyc.pop_back());
      end
      md_en = 0; md_mode = 0; md_period = DEF; md_led = 0; md_busy = 0; md_wr = 0;
      bstart = cyc;
    end else begin
      t = tgt(cyc - 1);
      if (md_busy) begin
        if (cyc == done_at) begin
          md_led  = md_wr;
          md_busy = 0;
        end
      end else if (t != md_led) begin
        md_busy = 1;
        md_wr   = t;
        done_at = cyc + 1 + stall_n;
        exp_lvl.push_back(t);
        exp_cyc.push_back(done_at);
      end
      if (chipselect && !write_n) begin
        if (address == 2'd0) begin
          md_en   = writedata[0];
          md_mode = writedata[1];
          bstart  = cyc;
        end else if (address == 2'd1) begin
          md_period = (writedata < 2) ? 2 : longint'(writedata);
          bstart    = cyc;
        end
      end
    end
  end

  // Monitor: compares every PIO write beat against the front of the expectation queue.
  initial forever begin
    @(negedge clk);
    if (reset_n && m_chipselect && !m_write_n) begin
      if (exp_lvl.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got data %0h with no write expected (edge %0d)", m_writedata, cyc);
      end else if (m_waitrequest) begin
        check("stall_data", m_writedata, {31'd0, exp_lvl[0]});
      end else begin
        check("wr_data", m_writedata, {31'd0, exp_lvl[0]});
        check("wr_edge", 32'(cyc + 1), 32'(exp_cyc[0]));
        check("wr_addr", {30'd0, m_address}, 32'd0);
        void'(exp_lvl.pop_front());
        void'(exp_cyc.pop_front());
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic csr_write(logic [1:0] a, logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic csr_read(logic [1:0] a, string nm);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    check(nm, readdata, exp_rd(a));
    chipselect = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      csr_read(2'($urandom_range(0, 3)), "run_read");
      tick(1);
    end
  endtask

  initial begin
    logic [31:0] rst_vals [4];
    rst_vals = '{32'd0, DEF, 32'd0, 32'd0};
    address = 0; chipselect = 0; write_n = 1; writedata = 0; reset_n = 0;
    tick(3);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check($sformatf("reset_read%0d", a), readdata, rst_vals[a]);
    end
    check("reset_cs", {31'd0, m_chipselect}, 32'd0);
    check("reset_wn", {31'd0, m_write_n}, 32'd1);
    check("reset_wd", m_writedata, 32'd0);
    reset_n = 1;
    tick(1);

    // Steady on: one write of 1.
    csr_write(2'd0, 32'd1);
    tick(4);
    csr_read(2'd2, "status_steady");
    check("status_steady_led", readdata, 32'd1);

    // Blink with period 5, no stalls.
    csr_write(2'd1, 32'd5);
    csr_write(2'd0, 32'd3);
    run(40);
    csr_write(2'd0, 32'd0);
    tick(10);

    // Same blink with 3-cycle stalls on every write.
    stall_n = 3;
    csr_write(2'd0, 32'd3);
    run(60);
    csr_write(2'd0, 32'd0);
    tick(12);

    // Period below minimum clamps to 2.
    stall_n = 0;
    csr_write(2'd1, 32'd0);
    csr_read(2'd1, "period_min");
    csr_write(2'd0, 32'd3);
    run(30);
    csr_write(2'd0, 32'd0);
    run(10);

    // Random CSR traffic under each stall depth.
    for (int s = 0; s < 3; s++) begin
      stall_n = s;
      for (int i = 0; i < 300; i++) begin
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0)      csr_write(2'd0, $urandom);
        else if (r == 1) csr_write(2'd1, 32'($urandom_range(0, 7)));
        else if (r == 2) csr_write(2'($urandom_range(2, 3)), $urandom);
        else begin
          csr_read(2'($urandom_range(0, 3)), "rand_read");
          tick(1);
        end
      end
      csr_write(2'd0, 32'd0);
      tick(12);
    end

    // Reset in the middle of a stalled write.
    stall_n = 3;
    csr_write(2'd0, 32'd1);
    tick(2);
    check("busy_before_reset", {31'd0, m_chipselect}, 32'd1);
    reset_n = 0;
    tick(1);
    check("rst_mid_cs", {31'd0, m_chipselect}, 32'd0);
    check("rst_mid_wn", {31'd0, m_write_n}, 32'd1);
    address = 2'd2;
    #1;
    check("rst_mid_status", readdata, 32'd0);
    reset_n = 1;
    stall_n = 0;
    tick(5);

    for (int i = 0; i < 50 && exp_lvl.size() != 0; i++) tick(1);
    check("queue_drained", 32'(exp_lvl.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
